mod_updown_counter: RTL and testbench
=====================================

MOD_UPDOWN_COUNTER -- requirements
Module: mod_updown_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 4: counter width in bits.
REQ-002 SHALL have parameter MODULUS, default 16: count range 0..MODULUS-1; legal range 2 <= MODULUS <= 2^WIDTH.
REQ-003 SHALL have parameter PRESCALE, default 1: count step taken once every PRESCALE enabled cycles; legal range PRESCALE >= 1.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-low reset; sampled on rising clk only.
REQ-006 en  input  1  count enable; advances prescaler when high.
REQ-007 up_dn  input  1  direction: 1 = up, 0 = down.
REQ-008 load  input  1  synchronous parallel load strobe.
REQ-009 load_val  input  WIDTH  value applied on load.
REQ-010 count  output  WIDTH  registered count value.
REQ-011 tc  output  1  terminal count, combinational from count and up_dn.
REQ-012 wrap  output  1  registered one-cycle pulse marking a wrap-around.

Function
REQ-013 SHALL apply per-edge priority: reset > load > count step > hold.
REQ-014 SHALL keep an internal prescaler pre_cnt in range 0..PRESCALE-1; it increments on each edge with en=1 and returns to 0 after PRESCALE-1; it holds when en=0.
REQ-015 SHALL take a count step on an edge where en=1 and pre_cnt==PRESCALE-1; with PRESCALE=1, every enabled edge is a step.
REQ-016 Up step: count+1; at MODULUS-1, count goes to 0 and wrap=1 on the next cycle.
REQ-017 Down step: count-1; at 0, count goes to MODULUS-1 and wrap=1 on the next cycle.
REQ-018 wrap SHALL be 0 on every edge without a wrapping step; it asserts in the same cycle as the wrapped count value.
REQ-019 load=1 SHALL set count=load_val, clear pre_cnt, and force wrap=0 regardless of en.
REQ-020 If load_val >= MODULUS, the load SHALL clamp count to MODULUS-1.
REQ-021 tc SHALL be 1 when (up_dn=1 and count==MODULUS-1) or (up_dn=0 and count==0); otherwise 0.
REQ-022 A change of up_dn SHALL NOT alter pre_cnt; the next step uses the new direction.
REQ-023 All arithmetic SHALL be modulo MODULUS; count SHALL never hold a value >= MODULUS.

Reset
REQ-024 On a rising edge with reset=0: count=0, pre_cnt=0, wrap=0; load and en are ignored that cycle.
REQ-025 Reset mid-prescale or mid-load SHALL discard all progress; counting resumes from 0 on the first enabled edge after reset=1.
REQ-026 After reset with up_dn=0, tc SHALL read 1 (count==0).

Configuration
REQ-027 Macro COUNTER_SAT_EN SHALL select saturating mode when defined.
REQ-028 With COUNTER_SAT_EN: an up step at MODULUS-1 holds MODULUS-1, a down step at 0 holds 0, and wrap is tied to 0; tc and load behaviour are unchanged.
REQ-029 Without COUNTER_SAT_EN: wrap-around behaviour per REQ-016 and REQ-017.

Verification (WIDTH=4, MODULUS=10, PRESCALE=1 unless stated)
REQ-030 Reset low 2 cycles, then en=1, up_dn=1 for 12 cycles -> count 0,1..9,0,1; wrap high only in the cycle count returns to 0; tc high while count=9.
REQ-031 Load load_val=3, then en=1, up_dn=0 for 5 cycles -> count 3,2,1,0,9,8; wrap pulses when count becomes 9; load_val=12 -> count=9.
REQ-032 PRESCALE=3, en=1 -> count steps every 3rd edge; en=0 for 2 cycles mid-prescale -> step delayed by exactly 2 cycles.
REQ-033 Simultaneous load=1, en=1 at count=9 up -> count=load_val, no wrap; reset=0 with load=1 -> count=0.
REQ-034 With COUNTER_SAT_EN defined: count up past 9 -> holds 9, wrap stays 0; count down from 0 -> holds 0.

Source files
------------

// File: rtl/mod_updown_counter.sv
// mod_updown_counter: modulo-MODULUS up/down counter with prescaler, load, tc, wrap.
// Define COUNTER_SAT_EN to saturate at the range ends instead of wrapping.
module mod_updown_counter #(
  parameter int WIDTH    = 4,
  parameter int MODULUS  = 16,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [WIDTH-1:0] CMAX  = WIDTH'(MODULUS - 1);
  localparam logic [PW-1:0]    PLAST = PW'(PRESCALE - 1);

  logic [PW-1:0]    pre_cnt;
  logic [PW-1:0]    pre_nxt;
  logic [WIDTH-1:0] cnt_nxt;
  logic [WIDTH-1:0] cnt_inc;
  logic [WIDTH-1:0] cnt_dec;
  logic [WIDTH-1:0] ld_sat;
  logic             wrap_nxt;
  logic             step;
  logic             at_max;
  logic             at_min;

  assign at_max  = (count == CMAX);
  assign at_min  = (count == '0);
  assign step    = en & (pre_cnt == PLAST);
  assign cnt_inc = count + WIDTH'(1);
  assign cnt_dec = count - WIDTH'(1);

  // Out-of-range loads clamp so count never leaves 0..MODULUS-1.
  assign ld_sat = (load_val > CMAX) ? CMAX : load_val;

  assign tc = up_dn ? at_max : at_min;

  always_comb begin
    pre_nxt  = pre_cnt;
    cnt_nxt  = count;
    wrap_nxt = 1'b0;
    priority case (1'b1)
      load: begin
        cnt_nxt = ld_sat;
        pre_nxt = '0;
      end
      step: begin
        pre_nxt = '0;
        if (up_dn) begin
          if (at_max) begin
`ifdef COUNTER_SAT_EN
            cnt_nxt = CMAX;
`else
            cnt_nxt  = '0;
            wrap_nxt = 1'b1;
`endif
          end else begin
            cnt_nxt = cnt_inc;
          end
        end else begin
          if (at_min) begin
`ifdef COUNTER_SAT_EN
            cnt_nxt = '0;
`else
            cnt_nxt  = CMAX;
            wrap_nxt = 1'b1;
`endif
          end else begin
            cnt_nxt = cnt_dec;
          end
        end
      end
      en: begin
        pre_nxt = pre_cnt + PW'(1);
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      count   <= '0;
      pre_cnt <= '0;
      wrap    <= 1'b0;
    end else begin
      count   <= cnt_nxt;
      pre_cnt <= pre_nxt;
      wrap    <= wrap_nxt;
    end
  end

endmodule

// File: tb/tb_mod_updown_counter.sv
// tb_mod_updown_counter: directed checks of mod_updown_counter.
// Instance a: MODULUS=10 PRESCALE=1; instance b: MODULUS=10 PRESCALE=3.
module tb_mod_updown_counter;

  logic       clk = 1'b0;
  logic       reset, en, up_dn, load;
  logic [3:0] load_val;
  logic [3:0] count;
  logic       tc, wrap;

  logic       b_reset, b_en, b_up_dn, b_load;
  logic [3:0] b_load_val;
  logic [3:0] b_count;
  logic       b_tc, b_wrap;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mod_updown_counter #(.WIDTH(4), .MODULUS(10), .PRESCALE(1)) u_a (
    .clk(clk), .reset(reset), .en(en), .up_dn(up_dn),
    .load(load), .load_val(load_val),
    .count(count), .tc(tc), .wrap(wrap)
  );

  mod_updown_counter #(.WIDTH(4), .MODULUS(10), .PRESCALE(3)) u_b (
    .clk(clk), .reset(b_reset), .en(b_en), .up_dn(b_up_dn),
    .load(b_load), .load_val(b_load_val),
    .count(b_count), .tc(b_tc), .wrap(b_wrap)
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic b_step(input string tag, input logic e, input logic u,
                        input int exp, input int expw);
    b_en    = e;
    b_up_dn = u;
    tick();
    check({tag, "_cnt"}, b_count, exp);
    check({tag, "_wrap"}, b_wrap, expw);
  endtask

`ifdef COUNTER_SAT_EN
  int exp_up[12]  = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 9, 9, 9};
  int exp_upw[12] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
  int exp_dn[5]   = '{2, 1, 0, 0, 0};
  int exp_dnw[5]  = '{0, 0, 0, 0, 0};
  int wrap_cnt    = 9;
  int wrap_flag   = 0;
  int b_low       = 0;
  int b_lowflag   = 0;
`else
  int exp_up[12]  = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
  int exp_upw[12] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0};
  int exp_dn[5]   = '{2, 1, 0, 9, 8};
  int exp_dnw[5]  = '{0, 0, 0, 1, 0};
  int wrap_cnt    = 0;
  int wrap_flag   = 1;
  int b_low       = 9;
  int b_lowflag   = 1;
`endif
  int ld_in[5]  = '{12, 15, 10, 9, 0};
  int ld_exp[5] = '{9, 9, 9, 9, 0};

  initial begin
    reset = 1'b0; en = 1'b1; up_dn = 1'b0;
    load = 1'b1; load_val = 4'd5;
    b_reset = 1'b0; b_en = 1'b0; b_up_dn = 1'b1;
    b_load = 1'b0; b_load_val = 4'd0;
    tick();
    tick();
    check("rst_cnt", count, 0);
    check("rst_wrap", wrap, 0);
    check("rst_tc", tc, 1);

    reset = 1'b1; load = 1'b0; en = 1'b1; up_dn = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      check("up_cnt", count, exp_up[i]);
      check("up_wrap", wrap, exp_upw[i]);
      check("up_tc", tc, (exp_up[i] == 9) ? 1 : 0);
    end

    load = 1'b1; load_val = 4'd3; up_dn = 1'b0;
    tick();
    check("ld3_cnt", count, 3);
    check("ld3_wrap", wrap, 0);
    load = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("dn_cnt", count, exp_dn[i]);
      check("dn_wrap", wrap, exp_dnw[i]);
      check("dn_tc", tc, (exp_dn[i] == 0) ? 1 : 0);
    end

    load = 1'b1;
    for (int i = 0; i < 5; i++) begin
      load_val = 4'(ld_in[i]);
      tick();
      check("ld_clamp", count, ld_exp[i]);
    end

    load_val = 4'd9; up_dn = 1'b1;
    tick();
    check("top_tc", tc, 1);
    load_val = 4'd5;
    tick();
    check("ld_en_cnt", count, 5);
    check("ld_en_wrap", wrap, 0);
    load_val = 4'd9;
    tick();
    load = 1'b0;
    tick();
    check("wrap_cnt", count, wrap_cnt);
    check("wrap_flag", wrap, wrap_flag);
    load = 1'b1; load_val = 4'd4;
    tick();
    check("ld_kill_cnt", count, 4);
    check("ld_kill_wrap", wrap, 0);
    load = 1'b0; en = 1'b0;
    tick();
    check("hold_cnt", count, 4);
    reset = 1'b0; load = 1'b1; load_val = 4'd7; en = 1'b1;
    tick();
    check("rst_ld_cnt", count, 0);
    check("rst_ld_wrap", wrap, 0);
    reset = 1'b1; load = 1'b0; en = 1'b0;

    tick();
    b_reset = 1'b1;
    b_step("ps1", 1, 1, 0, 0);
    b_step("ps2", 1, 1, 0, 0);
    b_step("ps3", 1, 1, 1, 0);
    b_step("ps4", 1, 1, 1, 0);
    b_step("gap1", 0, 1, 1, 0);
    b_step("gap2", 0, 1, 1, 0);
    b_step("ps5", 1, 1, 1, 0);
    b_step("ps6", 1, 1, 2, 0);
    b_step("dir1", 1, 1, 2, 0);
    b_step("dir2", 1, 0, 2, 0);
    b_step("dir3", 1, 0, 1, 0);
    b_step("dn1", 1, 0, 1, 0);
    b_step("dn2", 1, 0, 1, 0);
    b_step("dn3", 1, 0, 0, 0);
    b_step("dn4", 1, 0, 0, 0);
    b_step("dn5", 1, 0, 0, 0);
    b_step("dnw", 1, 0, b_low, b_lowflag);
    b_step("mid", 1, 0, b_low, 0);
    b_reset = 1'b0;
    b_step("brst", 1, 1, 0, 0);
    b_reset = 1'b1;
    b_step("res1", 1, 1, 0, 0);
    b_step("res2", 1, 1, 0, 0);
    b_step("res3", 1, 1, 1, 0);
    b_step("pl1", 1, 1, 1, 0);
    b_load = 1'b1; b_load_val = 4'd4;
    b_step("pld", 1, 1, 4, 0);
    b_load = 1'b0;
    b_step("pl2", 1, 1, 4, 0);
    b_step("pl3", 1, 1, 4, 0);
    b_step("pl4", 1, 1, 5, 0);
    check("b_tc", b_tc, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
